// File: rtl/overlay_compositor.sv
// Prioritised rectangle overlays over BG_COLOR; fixed 3+ROM_LAT cycle latency, free-running, no stalls.
// Define OVERLAY_SCALE2X_EN to honour the per-layer scale2x ctrl bit (2x2 pixel replication).
module overlay_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter int          COORD_W      = 10,
  parameter int          ADDR_W       = 16,
  parameter int          ROM_LAT      = 1,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COORD_W-1:0]           next_x,
  input  logic [COORD_W-1:0]           next_y,
  input  logic                         cfg_we,
  input  logic [2:0]                   cfg_layer,
  input  logic [2:0]                   cfg_field,
  input  logic [23:0]                  cfg_data,
  output logic [NUM_LAYERS*ADDR_W-1:0] rom_addr,
  input  logic [NUM_LAYERS-1:0]        rom_q,
  output logic [23:0]                  color_out,
  output logic                         hit,
  output logic [2:0]                   hit_layer,
  output logic                         frame_start
);

  localparam int EW    = COORD_W + 2;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [COORD_W-1:0] sh_x0 [NUM_LAYERS], sh_y0 [NUM_LAYERS], sh_w [NUM_LAYERS], sh_h [NUM_LAYERS];
  logic [COORD_W-1:0] act_x0[NUM_LAYERS], act_y0[NUM_LAYERS], act_w[NUM_LAYERS], act_h[NUM_LAYERS];
  logic [2:0]         sh_ctrl[NUM_LAYERS], act_ctrl[NUM_LAYERS];
  logic [23:0]        sh_col [NUM_LAYERS], act_col [NUM_LAYERS];

  logic             at0, at0_q;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_hid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        sh_x0[i] <= '0; sh_y0[i] <= '0; sh_w[i] <= '0; sh_h[i] <= '0;
        sh_ctrl[i] <= '0; sh_col[i] <= '0;
      end
    end else if (cfg_we) begin
      // out-of-range layer indices simply never match
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_layer == i[2:0]) begin
          case (cfg_field)
            3'd0: sh_x0[i]   <= cfg_data[COORD_W-1:0];
            3'd1: sh_y0[i]   <= cfg_data[COORD_W-1:0];
            3'd2: sh_w[i]    <= cfg_data[COORD_W-1:0];
            3'd3: sh_h[i]    <= cfg_data[COORD_W-1:0];
            3'd4: sh_ctrl[i] <= cfg_data[2:0];
            3'd5: sh_col[i]  <= cfg_data;
            default: ;
          endcase
        end
      end
    end
  end

  assign at0         = (next_x == '0) && (next_y == '0);
  assign frame_start = at0 && !at0_q && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      at0_q     <= 1'b0;
      blink_cnt <= '0;
      blink_hid <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        act_x0[i] <= '0; act_y0[i] <= '0; act_w[i] <= '0; act_h[i] <= '0;
        act_ctrl[i] <= '0; act_col[i] <= '0;
      end
    end else begin
      at0_q <= at0;
      if (frame_start) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          act_x0[i] <= sh_x0[i]; act_y0[i] <= sh_y0[i]; act_w[i] <= sh_w[i]; act_h[i] <= sh_h[i];
          act_ctrl[i] <= sh_ctrl[i]; act_col[i] <= sh_col[i];
        end
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_hid <= !blink_hid;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  logic [EW-1:0]           ext_w[NUM_LAYERS], ext_h[NUM_LAYERS];
  logic [COORD_W-1:0]      rx_c[NUM_LAYERS], ry_c[NUM_LAYERS], rx1[NUM_LAYERS], ry1[NUM_LAYERS];
  logic [NUM_LAYERS-1:0]   in_c, vis_c, sc_c, in1, vis1, scale_unused;
  logic [ADDR_W-1:0]       addr_c[NUM_LAYERS];
  logic [NUM_LAYERS*24-1:0] col_pk;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
`ifdef OVERLAY_SCALE2X_EN
      sc_c[i] = act_ctrl[i][2];
`else
      sc_c[i] = 1'b0;
`endif
      scale_unused[i] = act_ctrl[i][2];
      ext_w[i] = sc_c[i] ? {1'b0, act_w[i], 1'b0} : {2'b00, act_w[i]};
      ext_h[i] = sc_c[i] ? {1'b0, act_h[i], 1'b0} : {2'b00, act_h[i]};
      // widened compares keep x0+extent from wrapping past the coordinate range
      in_c[i] = act_ctrl[i][0]
             && ({2'b00, next_x} >= {2'b00, act_x0[i]})
             && ({2'b00, next_x} <  {2'b00, act_x0[i]} + ext_w[i])
             && ({2'b00, next_y} >= {2'b00, act_y0[i]})
             && ({2'b00, next_y} <  {2'b00, act_y0[i]} + ext_h[i]);
      vis_c[i] = !(act_ctrl[i][1] && blink_hid);
      rx_c[i]  = next_x - act_x0[i];
      ry_c[i]  = next_y - act_y0[i];
      if (sc_c[i]) begin
        rx_c[i] = rx_c[i] >> 1;
        ry_c[i] = ry_c[i] >> 1;
      end
      addr_c[i] = ADDR_W'(ry1[i]) * ADDR_W'(act_w[i]) + ADDR_W'(rx1[i]);
      col_pk[i*24 +: 24] = act_col[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in1  <= '0;
      vis1 <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        rx1[i] <= '0;
        ry1[i] <= '0;
      end
    end else begin
      in1  <= in_c;
      vis1 <= vis_c;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        rx1[i] <= rx_c[i];
        ry1[i] <= ry_c[i];
      end
    end
  end

  // index 0 is the address stage; index ROM_LAT lines up with rom_q
  logic [NUM_LAYERS-1:0]    live_p[ROM_LAT+1];
  logic [NUM_LAYERS*24-1:0] col_p [ROM_LAT+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      for (int j = 0; j <= ROM_LAT; j++) begin
        live_p[j] <= '0;
        col_p[j]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++)
        rom_addr[i*ADDR_W +: ADDR_W] <= in1[i] ? addr_c[i] : '0;
      live_p[0] <= in1 & vis1;
      col_p[0]  <= col_pk;
      for (int j = 1; j <= ROM_LAT; j++) begin
        live_p[j] <= live_p[j-1];
        col_p[j]  <= col_p[j-1];
      end
    end
  end

  logic        win_c;
  logic [2:0]  idx_c;
  logic [23:0] colw_c;

  always_comb begin
    win_c  = 1'b0;
    idx_c  = 3'd0;
    colw_c = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (live_p[ROM_LAT][i] && rom_q[i]) begin
        win_c  = 1'b1;
        idx_c  = i[2:0];
        colw_c = col_p[ROM_LAT][i*24 +: 24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_out <= BG_COLOR;
      hit       <= 1'b0;
      hit_layer <= 3'd0;
    end else begin
      color_out <= colw_c;
      hit       <= win_c;
      hit_layer <= idx_c;
    end
  end

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor; a cycle-tagged scoreboard checks composited output.
module tb_overlay_compositor;
  localparam int NL  = 4;
  localparam int CW  = 10;
  localparam int AW  = 16;
  localparam int RL  = 1;
  localparam int LAT = 3 + RL;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] next_x, next_y;
  logic          cfg_we;
  logic [2:0]    cfg_layer, cfg_field;
  logic [23:0]   cfg_data;
  logic [NL*AW-1:0] rom_addr;
  logic [NL-1:0] rom_q = '0;
  logic [NL-1:0] rom_mask;
  logic [23:0]   color_out;
  logic          hit;
  logic [2:0]    hit_layer;
  logic          frame_start;

  overlay_compositor #(
    .NUM_LAYERS(NL), .COORD_W(CW), .ADDR_W(AW), .ROM_LAT(RL),
    .BG_COLOR(24'h000000), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .next_x(next_x), .next_y(next_y),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .rom_addr(rom_addr), .rom_q(rom_q), .color_out(color_out), .hit(hit),
    .hit_layer(hit_layer), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  int fs_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_q <= rom_mask;
    if (frame_start) fs_cnt <= fs_cnt + 1;
  end

  typedef struct {
    int          due;
    logic [23:0] col;
    logic        hit;
    logic [2:0]  lay;
    string       tag;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int fs_base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample at the falling edge, then return just after the next rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk({e.tag, "_due"}, 32'(e.due), 32'(cyc));
      chk({e.tag, "_color"}, {8'h0, color_out}, {8'h0, e.col});
      chk({e.tag, "_hit"}, {31'h0, hit}, {31'h0, e.hit});
      chk({e.tag, "_layer"}, {29'h0, hit_layer}, {29'h0, e.lay});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] c, input logic h,
                     input logic [2:0] l, input string tag);
    exp_t e;
    next_x = CW'(x);
    next_y = CW'(y);
    e = '{due: cyc + LAT, col: c, hit: h, lay: l, tag: tag};
    q.push_back(e);
    step();
  endtask

  task automatic pix_addr(input int x, input int y, input logic [23:0] c, input logic h,
                          input logic [2:0] l, input logic [AW-1:0] a, input string tag);
    pix(x, y, c, h, l, tag);
    step();
    chk({tag, "_addr"}, 32'(rom_addr[AW-1:0]), 32'(a));
  endtask

  task automatic idle(input int n);
    next_x = CW'(5);
    next_y = CW'(5);
    repeat (n) step();
  endtask

  task automatic wr(input int l, input int f, input logic [23:0] d);
    cfg_we = 1'b1; cfg_layer = 3'(l); cfg_field = 3'(f); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic commit_wr(input logic we, input int l, input int f, input logic [23:0] d);
    next_x = CW'(1); next_y = CW'(1);
    step();
    next_x = '0; next_y = '0;
    cfg_we = we; cfg_layer = 3'(l); cfg_field = 3'(f); cfg_data = d;
    #1 chk("fs_pulse", {31'h0, frame_start}, 32'h1);
    step();
    cfg_we = 1'b0;
    #1 chk("fs_single", {31'h0, frame_start}, 32'h0);
    idle(1);
  endtask

  task automatic commit();
    commit_wr(1'b0, 0, 0, 24'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    q.delete();
    fs_base = fs_cnt;
  endtask

  task automatic cfg_layer_all(input int l, input int x0, input int y0, input int w, input int h,
                               input logic [23:0] c, input logic [2:0] ctrl);
    wr(l, 0, 24'(x0)); wr(l, 1, 24'(y0)); wr(l, 2, 24'(w)); wr(l, 3, 24'(h));
    wr(l, 5, c); wr(l, 4, {21'h0, ctrl});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
    rom_mask = '0; next_x = '0; next_y = '0;
    #5;
    chk("rst_color", {8'h0, color_out}, 32'h0);
    chk("rst_hit", {31'h0, hit}, 32'h0);
    chk("rst_layer", {29'h0, hit_layer}, 32'h0);
    chk("rst_addr", rom_addr[31:0], 32'h0);
    chk("rst_fs_gated", {31'h0, frame_start}, 32'h0);
    next_x = CW'(5); next_y = CW'(5);
    step();
    rst = 1'b1;
    step();

    // single layer, 1:1
    cfg_layer_all(0, 200, 120, 240, 120, 24'hFFFFFF, 3'b001);
    rom_mask = 4'b0001;
    pix(210, 130, 24'h000000, 1'b0, 3'd0, "pre_commit");
    idle(LAT + 1);
    commit();
    pix_addr(210, 130, 24'hFFFFFF, 1'b1, 3'd0, 16'd2410, "l0_hit");
    chk("l1_addr_zero", 32'(rom_addr[2*AW-1:AW]), 32'h0);
    pix(199, 130, 24'h000000, 1'b0, 3'd0, "left_edge_out");
    pix(200, 120, 24'hFFFFFF, 1'b1, 3'd0, "corner_in");
    pix(439, 239, 24'hFFFFFF, 1'b1, 3'd0, "far_corner_in");
    pix(440, 130, 24'h000000, 1'b0, 3'd0, "right_edge_out");
    pix(300, 240, 24'h000000, 1'b0, 3'd0, "bottom_edge_out");
    pix(300, 119, 24'h000000, 1'b0, 3'd0, "top_edge_out");
    idle(LAT + 1);
    rom_mask = 4'b0000;
    pix(210, 130, 24'h000000, 1'b0, 3'd0, "rom_zero");
    idle(LAT + 1);

    // asynchronous reset while showing a foreground pixel
    rom_mask = 4'b0001;
    next_x = CW'(210); next_y = CW'(130);
    repeat (LAT + 1) step();
    chk("pre_rst_color", {8'h0, color_out}, 32'hFFFFFF);
    #5 rst = 1'b0;
    #1;
    chk("async_rst_color", {8'h0, color_out}, 32'h0);
    chk("async_rst_hit", {31'h0, hit}, 32'h0);
    chk("async_rst_addr", rom_addr[31:0], 32'h0);
    step();
    rst = 1'b1;
    step();
    q.delete();
    fs_base = fs_cnt;

    // priority between overlapping layers
    cfg_layer_all(0, 200, 120, 240, 120, 24'hFF0000, 3'b001);
    cfg_layer_all(1, 200, 120, 100, 100, 24'h00FF00, 3'b001);
    commit();
    rom_mask = 4'b0011;
    pix(250, 150, 24'hFF0000, 1'b1, 3'd0, "overlap_l0");
    pix(350, 150, 24'hFF0000, 1'b1, 3'd0, "only_l0");
    idle(LAT + 1);
    rom_mask = 4'b0010;
    pix(250, 150, 24'h00FF00, 1'b1, 3'd1, "l0_transparent");
    idle(LAT + 1);
    rom_mask = 4'b0011;
    wr(0, 4, 24'h0);
    pix(250, 150, 24'hFF0000, 1'b1, 3'd0, "disable_pending");
    idle(LAT + 1);
    commit();
    pix(250, 150, 24'h00FF00, 1'b1, 3'd1, "disable_active");
    idle(LAT + 1);

    // shadow registers only take effect at frame start
    wr(0, 4, 24'h1);
    commit();
    rom_mask = 4'b0001;
    pix(250, 130, 24'hFF0000, 1'b1, 3'd0, "x0_200");
    idle(LAT + 1);
    wr(0, 0, 24'd300);
    pix(250, 130, 24'hFF0000, 1'b1, 3'd0, "x0_shadowed");
    idle(LAT + 1);
    commit();
    pix(250, 130, 24'h000000, 1'b0, 3'd0, "x0_300_out");
    pix(310, 130, 24'hFF0000, 1'b1, 3'd0, "x0_300_in");
    idle(LAT + 1);
    wr(7, 0, 24'd0);
    wr(0, 6, 24'd0);
    commit();
    pix(310, 130, 24'hFF0000, 1'b1, 3'd0, "bad_write_ignored");
    pix(250, 130, 24'h000000, 1'b0, 3'd0, "bad_write_ignored_out");
    idle(LAT + 1);
    commit_wr(1'b1, 0, 2, 24'd0);
    pix(310, 130, 24'hFF0000, 1'b1, 3'd0, "fs_write_deferred");
    idle(LAT + 1);
    commit();
    pix(310, 130, 24'h000000, 1'b0, 3'd0, "width_zero");
    idle(LAT + 1);

    // blink with a non-blinking layer underneath
    do_reset();
    cfg_layer_all(2, 600, 400, 10, 10, 24'h0000FF, 3'b011);
    cfg_layer_all(3, 600, 400, 10, 10, 24'h123456, 3'b001);
    rom_mask = 4'b1100;
    for (int f = 1; f <= 6; f++) begin
      commit();
      chk("fs_count", 32'(fs_cnt - fs_base), 32'(f));
      if (((f / 2) % 2) == 0)
        pix(605, 405, 24'h0000FF, 1'b1, 3'd2, "blink_visible");
      else
        pix(605, 405, 24'h123456, 1'b1, 3'd3, "blink_hidden");
      idle(LAT + 1);
    end

    // scale2x control bit
    do_reset();
    cfg_layer_all(0, 240, 100, 160, 50, 24'hAAAAAA, 3'b101);
    commit();
    rom_mask = 4'b0001;
`ifdef OVERLAY_SCALE2X_EN
    pix_addr(240, 100, 24'hAAAAAA, 1'b1, 3'd0, 16'd0, "sc_origin");
    pix_addr(241, 100, 24'hAAAAAA, 1'b1, 3'd0, 16'd0, "sc_replicate");
    pix_addr(559, 149, 24'hAAAAAA, 1'b1, 3'd0, 16'd3999, "sc_far");
    pix(560, 100, 24'h000000, 1'b0, 3'd0, "sc_right_out");
    pix(239, 100, 24'h000000, 1'b0, 3'd0, "sc_left_out");
`else
    pix_addr(241, 100, 24'hAAAAAA, 1'b1, 3'd0, 16'd1, "noscale_addr");
    pix(399, 100, 24'hAAAAAA, 1'b1, 3'd0, "noscale_last");
    pix(400, 100, 24'h000000, 1'b0, 3'd0, "noscale_out");
`endif
    idle(LAT + 1);

    for (int n = 0; n < 20 && q.size() > 0; n++) step();
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
